// File: rtl/tlb_refill_arbiter_pkg.sv
// Shared types and constants for the TLB refill read-port arbiter.
package tlb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } arb_state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_ITLB = 1'b0;
   localparam req_id_t REQ_DTLB = 1'b1;

endpackage

// File: rtl/tlb_refill_arbiter_rr_pick.sv
// Combinational 2-way round-robin selector: on a tie the requester that
// did not win last time is chosen.
module tlb_rr_pick
   import tlb_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   output logic       valid,
   output req_id_t    id
);

   always_comb begin
      valid = |req;
      if (&req) begin
         id = ~last;
      end else begin
         id = req[REQ_DTLB];
      end
   end

endmodule

// File: rtl/tlb_refill_arbiter.sv
// Shares one memory read port between the ITLB and DTLB refill engines with
// round-robin grant locked until the memory answers.
module tlb_refill_arbiter
   import tlb_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              ren_req,
   input  logic [ADDR_WIDTH-1:0]   raddr_req0,
   input  logic [ADDR_WIDTH-1:0]   raddr_req1,
   output logic [2*DATA_WIDTH-1:0] rdata_req,
   output logic [1:0]              rvalid_req,
   input  logic                    flush,
   output logic                    ren_mem,
   output logic [ADDR_WIDTH-1:0]   raddr_mem,
   input  logic [2*DATA_WIDTH-1:0] rdata_mem,
   input  logic                    rvalid_mem,
   output logic                    gnt_id
);

   arb_state_t              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;
   req_id_t                 gnt_q, gnt_d;
   req_id_t                 rr_last_q, rr_last_d;
   logic                    drop_q, drop_d;
   logic                    ren_mem_q, ren_mem_d;
   logic [1:0]              rvalid_q, rvalid_d;

   logic                    pick_valid;
   req_id_t                 pick_id;

   tlb_rr_pick u_pick (
      .req   (ren_req),
      .last  (rr_last_q),
      .valid (pick_valid),
      .id    (pick_id)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rdata_d   = rdata_q;
      gnt_d     = gnt_q;
      rr_last_d = rr_last_q;
      drop_d    = drop_q;
      rvalid_d  = '0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               gnt_d     = pick_id;
               addr_d    = (pick_id == REQ_DTLB) ? raddr_req1 : raddr_req0;
               rr_last_d = pick_id;
               drop_d    = 1'b0;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (flush) begin
               drop_d = 1'b1;
            end
            // A same-cycle flush or an abandoned request discards the line.
            if (rvalid_mem) begin
               if (drop_q || flush || !ren_req[gnt_q]) begin
                  state_d = IDLE;
               end else begin
                  rdata_d         = rdata_mem;
                  rvalid_d[gnt_q] = 1'b1;
                  state_d         = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ren_mem_d = (state_d == BUSY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rdata_q   <= '0;
         gnt_q     <= REQ_ITLB;
         rr_last_q <= REQ_DTLB;
         drop_q    <= 1'b0;
         ren_mem_q <= 1'b0;
         rvalid_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rdata_q   <= rdata_d;
         gnt_q     <= gnt_d;
         rr_last_q <= rr_last_d;
         drop_q    <= drop_d;
         ren_mem_q <= ren_mem_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign ren_mem    = ren_mem_q;
   assign raddr_mem  = addr_q;
   assign rdata_req  = rdata_q;
   assign rvalid_req = rvalid_q;
   assign gnt_id     = gnt_q;

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// Self-checking bench for tlb_refill_arbiter: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_tlb_refill_arbiter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      ren_req = '0;
   logic [AW-1:0]   raddr_req0 = '0;
   logic [AW-1:0]   raddr_req1 = '0;
   logic [2*DW-1:0] rdata_req;
   logic [1:0]      rvalid_req;
   logic            flush = 1'b0;
   logic            ren_mem;
   logic [AW-1:0]   raddr_mem;
   logic [2*DW-1:0] rdata_mem = '0;
   logic            rvalid_mem = 1'b0;
   logic            gnt_id;

   tlb_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .ren_req    (ren_req),
      .raddr_req0 (raddr_req0),
      .raddr_req1 (raddr_req1),
      .rdata_req  (rdata_req),
      .rvalid_req (rvalid_req),
      .flush      (flush),
      .ren_mem    (ren_mem),
      .raddr_mem  (raddr_mem),
      .rdata_mem  (rdata_mem),
      .rvalid_mem (rvalid_mem),
      .gnt_id     (gnt_id)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: who is requesting, their addresses, the previous
   // winner, and the last line actually delivered to a requester.
   bit              want [2];
   logic [AW-1:0]   maddr [2];
   int              m_last = 1;
   logic [2*DW-1:0] last_data = '0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic post_req();
      ren_req    = {want[1], want[0]};
      raddr_req0 = maddr[0];
      raddr_req1 = maddr[1];
   endtask

   task automatic model_reset();
      want[0]   = 1'b0;
      want[1]   = 1'b0;
      m_last    = 1;
      last_data = '0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ren_mem"}, 128'(ren_mem), 128'(0));
      chk({tag, "_raddr_mem"}, 128'(raddr_mem), 128'(0));
      chk({tag, "_rvalid_req"}, 128'(rvalid_req), 128'(0));
      chk({tag, "_rdata_req"}, rdata_req, 128'(0));
      chk({tag, "_gnt_id"}, 128'(gnt_id), 128'(0));
   endtask

   // Called just after a negedge with the DUT idle and at least one want set.
   // lat: BUSY cycle (1-based) carrying rvalid_mem; flush_at/abandon_at: BUSY
   // cycle of a flush pulse / grantee drop (0 = none).
   task automatic run_txn(input int lat, input int flush_at, input int abandon_at,
                          input bit resp_flush, input logic [127:0] data, output int w);
      bit discarded;
      post_req();
      if (want[0] && want[1]) w = 1 - m_last;
      else                    w = want[1] ? 1 : 0;
      m_last = w;
      @(posedge clk); #1;
      chk("grant_ren_mem", 128'(ren_mem), 128'(1));
      chk("grant_raddr", 128'(raddr_mem), 128'(maddr[w]));
      chk("grant_id", 128'(gnt_id), 128'(w));
      chk("grant_rvalid", 128'(rvalid_req), 128'(0));
      discarded = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         flush      = (k == flush_at);
         rvalid_mem = (k == lat);
         rdata_mem  = (k == lat) ? data : rand_line();
         if (k == flush_at) discarded = 1'b1;
         if (k == abandon_at) begin
            want[w]   = 1'b0;
            discarded = 1'b1;
            post_req();
         end
         @(posedge clk); #1;
         if (k < lat) chk("busy_ren_mem", 128'(ren_mem), 128'(1));
      end
      chk("resp_ren_mem", 128'(ren_mem), 128'(0));
      if (discarded) begin
         chk("drop_rvalid", 128'(rvalid_req), 128'(0));
         chk("drop_rdata_hold", rdata_req, last_data);
         @(negedge clk);
         flush      = 1'b0;
         rvalid_mem = 1'b0;
      end else begin
         chk("resp_rvalid", 128'(rvalid_req), 128'(2'b01 << w));
         chk("resp_rdata", rdata_req, data);
         last_data = data;
         @(negedge clk);
         flush      = resp_flush;
         rvalid_mem = $urandom_range(0, 1);
         rdata_mem  = rand_line();
         want[w]    = 1'b0;
         post_req();
         @(posedge clk); #1;
         chk("after_rvalid", 128'(rvalid_req), 128'(0));
         chk("after_ren_mem", 128'(ren_mem), 128'(0));
         chk("after_rdata_hold", rdata_req, last_data);
         chk("after_gnt_id", 128'(gnt_id), 128'(w));
         @(negedge clk);
         flush      = 1'b0;
         rvalid_mem = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      post_req();
      flush      = 1'b0;
      rvalid_mem = 1'b0;
      @(posedge clk); #1;
      chk_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int w;
      int lat, fa, aa;
      model_reset();
      maddr[0] = '0;
      maddr[1] = '0;
      do_reset();

      // Single ITLB request, memory answers 4 cycles after ren_mem.
      want[0]  = 1'b1;
      maddr[0] = 64'h8000_1000;
      run_txn(5, 0, 0, 1'b0, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, w);

      // Simultaneous requests straight after reset: ITLB then DTLB.
      do_reset();
      want[0] = 1'b1; maddr[0] = {$urandom, $urandom};
      want[1] = 1'b1; maddr[1] = {$urandom, $urandom};
      run_txn(2, 0, 0, 1'b0, rand_line(), w);
      run_txn(1, 0, 0, 1'b0, rand_line(), w);

      // Continuous contention: alternating grants.
      for (int i = 0; i < 6; i++) begin
         for (int r = 0; r < 2; r++) begin
            if (!want[r]) begin
               want[r]  = 1'b1;
               maddr[r] = {$urandom, $urandom};
            end
         end
         run_txn(int'($urandom_range(1, 3)), 0, 0, 1'b0, rand_line(), w);
      end

      // Flush mid-BUSY, flush with rvalid_mem, flush in RESP, abandon.
      want[0] = 1'b1; maddr[0] = {$urandom, $urandom};
      want[1] = 1'b1; maddr[1] = {$urandom, $urandom};
      run_txn(4, 2, 0, 1'b0, rand_line(), w);
      run_txn(3, 0, 0, 1'b0, rand_line(), w);
      run_txn(3, 3, 0, 1'b0, rand_line(), w);
      if (!want[0]) begin want[0] = 1'b1; maddr[0] = {$urandom, $urandom}; end
      if (!want[1]) begin want[1] = 1'b1; maddr[1] = {$urandom, $urandom}; end
      run_txn(2, 0, 0, 1'b1, rand_line(), w);
      run_txn(3, 0, 2, 1'b0, rand_line(), w);

      // Reset in BUSY, then a late rvalid_mem while idle.
      @(negedge clk);
      want[0] = 1'b0; want[1] = 1'b0; post_req();
      want[1] = 1'b1; maddr[1] = {$urandom, $urandom}; post_req();
      @(posedge clk); #1;
      chk("rst_busy_ren_mem", 128'(ren_mem), 128'(1));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_state("rst_busy");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      post_req();
      rvalid_mem = 1'b1;
      rdata_mem  = rand_line();
      @(posedge clk); #1;
      chk("late_rvalid_req", 128'(rvalid_req), 128'(0));
      chk("late_ren_mem", 128'(ren_mem), 128'(0));
      @(posedge clk); #1;
      chk("late_rvalid_req2", 128'(rvalid_req), 128'(0));
      chk("late_rdata", rdata_req, 128'(0));
      @(negedge clk);
      rvalid_mem = 1'b0;

      // Randomized transactions.
      for (int i = 0; i < 200; i++) begin
         for (int r = 0; r < 2; r++) begin
            if (!want[r] && ($urandom_range(0, 1) == 1)) begin
               want[r]  = 1'b1;
               maddr[r] = {$urandom, $urandom};
            end
         end
         if (!want[0] && !want[1]) begin
            w        = int'($urandom_range(0, 1));
            want[w]  = 1'b1;
            maddr[w] = {$urandom, $urandom};
         end
         lat = int'($urandom_range(1, 5));
         fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
         aa  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : 0;
         run_txn(lat, fa, aa, 1'($urandom_range(0, 1)), rand_line(), w);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
